// File: rtl/gamepad_pkg.sv
// Shared types and constants for the gamepad PMOD transmitter: FSM states,
// button bit positions within a 12-bit controller word, and frame layout.
package gamepad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_t;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    localparam int          FRAME_BITS  = 24;
    localparam logic [11:0] ABSENT_WORD = 12'hFFF;

    // Controller 2 occupies the upper word so it leaves the shifter first.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [11:0] b1,
                                                         input logic [11:0] b2,
                                                         input logic        p2);
        return {(p2 ? b2 : ABSENT_WORD), b1};
    endfunction

endpackage

// File: rtl/pmod_phase_tick.sv
// Half-period strobe generator: tick pulses on every HALF_DIV-th enabled cycle.
// Deasserting en restarts the count, so each enabled run begins on a fresh phase.
module pmod_phase_tick #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam logic [7:0] LAST = 8'(HALF_DIV - 1);

    logic [7:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt <= 8'd0;
        end else if (tick) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/gamepad_pmod_tx.sv
// Serialises a two-controller button snapshot onto a PMOD clock/data/latch link.
// Optional back-to-back framing when GAMEPAD_PMOD_TX_CONT_EN is defined.
module gamepad_pmod_tx
    import gamepad_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int GAP_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] btn1,
    input  logic [11:0] btn2,
    input  logic        present2,
    input  logic        start,
    output logic        pmod_data,
    output logic        pmod_clk,
    output logic        pmod_latch,
    output logic        busy,
    output logic        frame_done
);

    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [9:0] GAP_LAST = 10'(GAP_CYC - 1);

    tx_state_t             state_q, state_d;
    logic [FRAME_BITS-1:0] shreg_q, shreg_d;
    logic [4:0]            bit_q, bit_d;
    logic [9:0]            gap_q, gap_d;
    logic                  sclk_d;
    logic                  data_d, clk_out_d, latch_d, busy_d, done_d;
    logic                  phase_en, tick;

    assign phase_en = (state_q == ST_SHIFT) || (state_q == ST_LATCH);

    pmod_phase_tick #(
        .HALF_DIV(HALF_DIV)
    ) u_phase_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (phase_en),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        sclk_d  = pmod_clk;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    shreg_d = make_frame(btn1, btn2, present2);
                    bit_d   = 5'd0;
                    sclk_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!pmod_clk) begin
                        sclk_d = 1'b1;
                    end else begin
                        // Falling edge of pmod_clk is the only point where data advances.
                        sclk_d = 1'b0;
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_LATCH;
                            bit_d   = 5'd0;
                        end else begin
                            bit_d   = bit_q + 5'd1;
                            shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end
            end
            ST_LATCH: begin
                sclk_d = 1'b0;
                if (tick) begin
                    state_d = ST_GAP;
                    gap_d   = 10'd0;
                end
            end
            ST_GAP: begin
                sclk_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    gap_d = 10'd0;
`ifdef GAMEPAD_PMOD_TX_CONT_EN
                    state_d = ST_SHIFT;
                    shreg_d = make_frame(btn1, btn2, present2);
                    bit_d   = 5'd0;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    gap_d = gap_q + 10'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from next-state values and registered, so pins never glitch.
        data_d    = (state_d == ST_SHIFT) && shreg_d[FRAME_BITS-1];
        clk_out_d = (state_d == ST_SHIFT) && sclk_d;
        latch_d   = (state_d == ST_LATCH);
        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_GAP) && (gap_d == GAP_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_q      <= 5'd0;
            gap_q      <= 10'd0;
            pmod_data  <= 1'b0;
            pmod_clk   <= 1'b0;
            pmod_latch <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_q      <= bit_d;
            gap_q      <= gap_d;
            pmod_data  <= data_d;
            pmod_clk   <= clk_out_d;
            pmod_latch <= latch_d;
            busy       <= busy_d;
            frame_done <= done_d;
        end
    end

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench for gamepad_pmod_tx at default parameters (frame = 212 cycles).
module tb_gamepad_pmod_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] btn1, btn2;
    logic        present2, start;
    logic        pmod_data, pmod_clk, pmod_latch, busy, frame_done;

    int checks = 0;
    int errors = 0;

    gamepad_pmod_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn1      (btn1),
        .btn2      (btn2),
        .present2  (present2),
        .start     (start),
        .pmod_data (pmod_data),
        .pmod_clk  (pmod_clk),
        .pmod_latch(pmod_latch),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses start, then watches one frame until busy falls. act_kind at busy
    // cycle act_cyc: 1 = flip btn1 to FFF, 2 = pulse start, 3 = assert reset.
    task automatic run_frame(input int act_cyc, input int act_kind,
                             output logic [23:0] word, output int blen,
                             output int latch_w, output int dones,
                             output int rises, output int unstable);
        logic prev_clk, hold;
        word = '0; blen = 0; latch_w = 0; dones = 0; rises = 0; unstable = 0;
        prev_clk = 1'b0; hold = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            start = 1'b0;
            if (!busy) break;
            if (pmod_clk && !prev_clk) begin
                word = {word[22:0], pmod_data};
                hold = pmod_data;
                rises++;
            end else if (pmod_clk && (pmod_data !== hold)) begin
                unstable++;
            end
            prev_clk = pmod_clk;
            if (pmod_latch) latch_w++;
            if (frame_done) dones++;
            if (c == act_cyc) begin
                case (act_kind)
                    1: btn1 = 12'hFFF;
                    2: start = 1'b1;
                    3: rst_n = 1'b0;
                    default: ;
                endcase
            end
            blen++;
            @(negedge clk);
            if (act_kind == 3 && c == act_cyc) break;
        end
    endtask

    logic [23:0] word;
    int blen, latch_w, dones, rises, unstable, idle_busy;

    initial begin
        rst_n = 1'b0; start = 1'b0; btn1 = '0; btn2 = '0; present2 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs", {27'd0, pmod_data, pmod_clk, pmod_latch, busy, frame_done}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef GAMEPAD_PMOD_TX_CONT_EN
        begin
            int cyc, last, frames;
            logic prevl, prevc;
            btn1 = 12'h001; btn2 = 12'h000; present2 = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc = 0; last = 0; frames = 0; prevl = 1'b0; prevc = 1'b0; word = '0;
            while (frames < 5 && cyc < 3000) begin
                if (pmod_clk && !prevc) word = {word[22:0], pmod_data};
                prevc = pmod_clk;
                if (pmod_latch && !prevl) begin
                    check_eq($sformatf("cont_word%0d", frames), {8'd0, word}, {8'd0, 12'h000, 12'h001 + 12'(frames)});
                    if (frames > 0) check_eq($sformatf("cont_spacing%0d", frames), cyc - last, 212);
                    last = cyc;
                    frames++;
                    btn1 = 12'h001 + 12'(frames);
                end
                prevl = pmod_latch;
                @(negedge clk);
                cyc++;
            end
            check_eq("cont_frames", frames, 5);
            check_eq("cont_busy_high", {31'd0, busy}, 32'd1);
        end
`else
        // Only the up button on controller 1.
        btn1 = 12'h080; btn2 = 12'h000; present2 = 1'b1;
        run_frame(-1, 0, word, blen, latch_w, dones, rises, unstable);
        check_eq("t1_word", {8'd0, word}, 32'h0000_0080);
        check_eq("t1_rises", rises, 24);
        check_eq("t1_latch_width", latch_w, 4);
        check_eq("t1_busy_len", blen, 212);
        check_eq("t1_done_pulses", dones, 1);
        check_eq("t1_data_stable", unstable, 0);

        // Absent controller 2 reads as all ones.
        btn1 = 12'hA05; btn2 = 12'h123; present2 = 1'b0;
        run_frame(-1, 0, word, blen, latch_w, dones, rises, unstable);
        check_eq("t2_word", {8'd0, word}, 32'h00FF_FA05);
        check_eq("t2_busy_len", blen, 212);
        check_eq("t2_done_pulses", dones, 1);

        // Inputs changing mid-frame must not leak into the frame.
        btn1 = 12'h000; btn2 = 12'h5A5; present2 = 1'b1;
        run_frame(40, 1, word, blen, latch_w, dones, rises, unstable);
        check_eq("t3_word", {8'd0, word}, 32'h005A_5000);
        check_eq("t3_busy_len", blen, 212);

        // Start while busy, including on the frame_done cycle, is dropped.
        btn1 = 12'h3C3; btn2 = 12'h000;
        run_frame(10, 2, word, blen, latch_w, dones, rises, unstable);
        check_eq("t4_word", {8'd0, word}, 32'h0000_03C3);
        check_eq("t4_busy_len", blen, 212);
        run_frame(211, 2, word, blen, latch_w, dones, rises, unstable);
        check_eq("t4b_busy_len", blen, 212);
        start = 1'b0;
        idle_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) idle_busy++;
            @(negedge clk);
        end
        check_eq("t4_no_requeue", idle_busy, 0);

        // Reset in the middle of bit 13 aborts with no latch.
        btn1 = 12'hFFF; btn2 = 12'hFFF;
        run_frame(106, 3, word, blen, latch_w, dones, rises, unstable);
        check_eq("t5_outputs_after_reset", {27'd0, pmod_data, pmod_clk, pmod_latch, busy, frame_done}, 32'd0);
        check_eq("t5_no_latch", latch_w, 0);
        check_eq("t5_rises_before_abort", rises, 13);
        rst_n = 1'b1;
        @(negedge clk);
        btn1 = 12'h123; btn2 = 12'h456;
        run_frame(-1, 0, word, blen, latch_w, dones, rises, unstable);
        check_eq("t5_recover_word", {8'd0, word}, 32'h0045_6123);
        check_eq("t5_recover_rises", rises, 24);
        check_eq("t5_recover_latch", latch_w, 4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gamepad_pmod_tx.md
GAMEPAD_PMOD_TX -- requirements
Module: gamepad_pmod_tx

Interface
REQ-001 SHALL have parameter HALF_DIV, default 4, meaning clk cycles per pmod_clk half-period (legal range 2..255).
REQ-002 SHALL have parameter GAP_CYC, default 16, meaning idle clk cycles after latch before the frame ends (legal range 1..1023).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port btn1, input, 12, controller-1 buttons, active-high, bit order [11:0] = {b,y,select,start,up,down,left,right,a,x,l,r}.
REQ-006 SHALL have port btn2, input, 12, controller-2 buttons, same order as btn1.
REQ-007 SHALL have port present2, input, 1, controller-2 present; 0 forces its word to 12'hFFF.
REQ-008 SHALL have port start, input, 1, one-cycle request to send one frame.
REQ-009 SHALL have port pmod_data, output, 1, serial data.
REQ-010 SHALL have port pmod_clk, output, 1, shift clock; the receiver samples on its rising edge.
REQ-011 SHALL have port pmod_latch, output, 1, frame-capture strobe.
REQ-012 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse on the last GAP cycle.

Function
REQ-014 SHALL implement states IDLE, SHIFT, LATCH, GAP; IDLE->SHIFT on start; SHIFT->LATCH after bit 24; LATCH->GAP after HALF_DIV cycles; GAP->IDLE after GAP_CYC cycles.
REQ-015 SHALL snapshot {present2 ? btn2 : 12'hFFF, btn1} into a 24-bit shift register on the cycle start is sampled in IDLE; later input changes SHALL NOT affect the frame in flight.
REQ-016 SHALL send the snapshot MSB first: controller-2 word bits 23..12, then controller-1 word bits 11..0.
REQ-017 Per bit SHALL drive pmod_clk low for HALF_DIV cycles, then high for HALF_DIV cycles; pmod_data SHALL change only on the cycle pmod_clk goes low and hold stable through the high phase.
REQ-018 SHALL drive the first bit on pmod_data and raise busy in the cycle after start is sampled (latency 1).
REQ-019 In LATCH SHALL hold pmod_latch high and pmod_clk low for HALF_DIV cycles; pmod_latch SHALL be low in every other state.
REQ-020 Frame length SHALL be exactly 48*HALF_DIV + HALF_DIV + GAP_CYC cycles (212 at defaults), from busy rising to busy falling.
REQ-021 SHALL ignore start while busy is high, with no queuing; a start that coincides with frame_done SHALL be ignored.
REQ-022 In IDLE and GAP SHALL drive pmod_clk=0, pmod_latch=0, pmod_data=0.
REQ-023 SHALL count bits with a 5-bit counter (0..23) and the phase with an 8-bit counter; the GAP counter SHALL be 10 bits; no counter SHALL wrap inside a state.

Reset
REQ-024 rst_n=0 at a clk edge SHALL force IDLE, clear the shift register and all counters, and set pmod_data, pmod_clk, pmod_latch, busy and frame_done to 0 on that edge.
REQ-025 Reset mid-frame SHALL abort the frame immediately, with no latch pulse emitted; start SHALL be ignored while rst_n=0.

Configuration
REQ-026 With macro GAMEPAD_PMOD_TX_CONT_EN defined, GAP SHALL return directly to SHIFT with a fresh snapshot after GAP_CYC cycles, whether or not start is asserted, so frames are back-to-back; frame_done SHALL still pulse; busy SHALL stay high from the first start onward.
REQ-027 Without GAMEPAD_PMOD_TX_CONT_EN, frames SHALL be sent only on start, per REQ-014.

Structure
REQ-028 Package gamepad_pkg SHALL hold the state enum, the button bit-index constants (BTN_B=11 ... BTN_R=0), FRAME_BITS=24 and ABSENT_WORD=12'hFFF.
REQ-029 Sub-module pmod_phase_tick SHALL generate the HALF_DIV phase-tick strobe; the FSM and shifter SHALL stay in gamepad_pmod_tx.

Verification
REQ-030 Test: btn1=12'h080 (up), present2=1, btn2=12'h000, start pulse -> 24 rising pmod_clk edges sample 000000000000_000010000000, then one latch pulse 4 cycles wide.
REQ-031 Test: present2=0, btn1=12'hA05 -> sampled word = 24'hFFFA05; busy is high for exactly 212 cycles; frame_done pulses once.
REQ-032 Test: btn1 changes 0x000->0xFFF at bit 5 of a frame -> the frame still carries 0x000 for controller 1.
REQ-033 Test: start pulsed on busy cycles 10 and 211 -> no second frame; busy returns to 0 and stays 0.
REQ-034 Test: rst_n=0 during bit 13 -> on the next edge all outputs are 0 and no latch occurs; a later start sends a complete frame.
REQ-035 Test: with GAMEPAD_PMOD_TX_CONT_EN defined, a single start -> latch pulses spaced exactly 212 cycles apart for 5 frames, each frame carrying the current inputs at its snapshot.
